// File: rtl/arm_instr_encoder.sv
// rtl/arm_instr_encoder.sv - field-level ARM instruction encoder and sequential instruction-memory loader
module arm_instr_encoder #(
    parameter int          ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [3:0]        in_cmd,
    input  logic [3:0]        in_cond,
    input  logic              in_i,
    input  logic              in_l,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rm,
    input  logic [23:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(1 << ADDR_W);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic        legal;
    logic [31:0] word;
    logic [11:0] op2;
    logic        cmd_ok;
    logic        accept;

    // Pure field packing; legality gates whether the word is ever written.
    always_comb begin
        legal  = 1'b0;
        word   = 32'h0;
        op2    = 12'h0;
        cmd_ok = (in_cmd == 4'b0100) || (in_cmd == 4'b0010) ||
                 (in_cmd == 4'b0000) || (in_cmd == 4'b1100);
        case (in_op)
            2'b00: begin
                op2   = in_i ? {4'b0000, in_imm[7:0]} : {8'h00, in_rm};
                word  = {in_cond, 2'b00, in_i, in_cmd, 1'b0, in_rn, in_rd, op2};
                legal = cmd_ok && !(in_i && (in_imm[23:8] != 16'h0));
            end
            2'b01: begin
                word  = {in_cond, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, in_l,
                         in_rn, in_rd, in_imm[11:0]};
                legal = (in_imm[23:12] == 12'h0);
            end
            2'b10: begin
                word  = {in_cond, 2'b10, 2'b10, in_imm};
                legal = 1'b1;
            end
            default: begin
                word  = 32'h0;
                legal = 1'b0;
            end
        endcase
    end

    assign accept = in_valid && (state_q == S_RUN);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    ptr_d   = BASE_C;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (legal) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = word;
                        ptr_d   = ptr_q + 1'b1;
                        count_d = count_q + 1'b1;
                        // Memory full: close the session; flag it unless the source also ended here.
                        if ((count_q + 1'b1) == DEPTH_C) begin
                            state_d = S_DONE;
                            if (!in_last) err_d = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    if (in_last) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign in_ready  = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign count     = count_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_arm_instr_encoder.sv
// tb/tb_arm_instr_encoder.sv - scoreboard bench for arm_instr_encoder (default and ADDR_W=2/BASE_ADDR=2 instances)
module tb_arm_instr_encoder;

    typedef struct packed {
        logic [1:0]  op;
        logic [3:0]  cmd;
        logic [3:0]  cond;
        logic        i;
        logic        l;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [23:0] imm;
        logic        last;
    } desc_t;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst;
    logic [1:0] st;
    logic [1:0] vld;
    desc_t      drv;

    logic        rdy0, we0, busy0, done0, err0;
    logic [5:0]  addr0;
    logic [31:0] wd0;
    logic [6:0]  cnt0;
    logic        rdy1, we1, busy1, done1, err1;
    logic [1:0]  addr1;
    logic [31:0] wd1;
    logic [2:0]  cnt1;

    int n_vec  = 0;
    int n_fail = 0;

    exp_t q0[$];
    exp_t q1[$];

    int unsigned m_ptr[2];
    int unsigned m_cnt[2];
    bit          m_err[2];
    bit          m_done[2];
    int unsigned depth[2] = '{64, 4};
    int unsigned base[2]  = '{0, 2};

    arm_instr_encoder #(.ADDR_W(6), .BASE_ADDR(0)) dut0 (
        .clk(clk), .reset(rst[0]), .start(st[0]), .in_valid(vld[0]), .in_ready(rdy0),
        .in_op(drv.op), .in_cmd(drv.cmd), .in_cond(drv.cond), .in_i(drv.i), .in_l(drv.l),
        .in_rd(drv.rd), .in_rn(drv.rn), .in_rm(drv.rm), .in_imm(drv.imm), .in_last(drv.last),
        .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
        .busy(busy0), .done(done0), .err(err0), .count(cnt0)
    );

    arm_instr_encoder #(.ADDR_W(2), .BASE_ADDR(2)) dut1 (
        .clk(clk), .reset(rst[1]), .start(st[1]), .in_valid(vld[1]), .in_ready(rdy1),
        .in_op(drv.op), .in_cmd(drv.cmd), .in_cond(drv.cond), .in_i(drv.i), .in_l(drv.l),
        .in_rd(drv.rd), .in_rn(drv.rn), .in_rm(drv.rm), .in_imm(drv.imm), .in_last(drv.last),
        .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
        .busy(busy1), .done(done1), .err(err1), .count(cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic o_rdy(input int s);  return s ? rdy1 : rdy0;   endfunction
    function automatic logic o_we(input int s);   return s ? we1 : we0;     endfunction
    function automatic logic o_busy(input int s); return s ? busy1 : busy0; endfunction
    function automatic logic o_done(input int s); return s ? done1 : done0; endfunction
    function automatic logic o_err(input int s);  return s ? err1 : err0;   endfunction
    function automatic logic [31:0] o_addr(input int s);
        return s ? {30'h0, addr1} : {26'h0, addr0};
    endfunction
    function automatic logic [31:0] o_wd(input int s); return s ? wd1 : wd0; endfunction
    function automatic logic [31:0] o_cnt(input int s);
        return s ? {29'h0, cnt1} : {25'h0, cnt0};
    endfunction

    // Reference encoding from the ARM field layout, built by arithmetic on whole words.
    function automatic bit ref_enc(input desc_t d, output logic [31:0] w);
        int unsigned c, cmd, ib, lb, rd, rn, rm, imm;
        bit ok;
        c = d.cond; cmd = d.cmd; ib = d.i; lb = d.l;
        rd = d.rd; rn = d.rn; rm = d.rm; imm = d.imm;
        w  = 32'h0;
        ok = 1'b0;
        case (d.op)
            2'd0: begin
                ok = (cmd == 4 || cmd == 2 || cmd == 0 || cmd == 12) && !(ib == 1 && imm > 255);
                w  = c * 32'h1000_0000 + ib * 32'h0200_0000 + cmd * 32'h0020_0000 +
                     rn * 32'h1_0000 + rd * 32'h1000 + ((ib == 1) ? (imm % 256) : rm);
            end
            2'd1: begin
                ok = imm < 4096;
                w  = c * 32'h1000_0000 + 32'h0400_0000 + 32'h0100_0000 + 32'h0080_0000 +
                     lb * 32'h0010_0000 + rn * 32'h1_0000 + rd * 32'h1000 + (imm % 4096);
            end
            2'd2: begin
                ok = 1'b1;
                w  = c * 32'h1000_0000 + 32'h0800_0000 + 32'h0200_0000 + imm;
            end
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic desc_t mk(input logic [1:0] op, input logic [3:0] cmd, input logic [3:0] cond,
                                 input logic i, input logic l, input logic [3:0] rd,
                                 input logic [3:0] rn, input logic [3:0] rm,
                                 input logic [23:0] imm, input logic last);
        desc_t d;
        d.op = op; d.cmd = cmd; d.cond = cond; d.i = i; d.l = l;
        d.rd = rd; d.rn = rn; d.rm = rm; d.imm = imm; d.last = last;
        return d;
    endfunction

    function automatic desc_t rnd();
        desc_t d;
        int k;
        d.op   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        k      = $urandom_range(0, 7);
        d.cmd  = (k < 2) ? 4'd4 : (k < 4) ? 4'd2 : (k < 5) ? 4'd0 : (k < 7) ? 4'd12 : 4'($urandom);
        d.cond = 4'($urandom);
        d.i    = 1'($urandom);
        d.l    = 1'($urandom);
        d.rd   = 4'($urandom);
        d.rn   = 4'($urandom);
        d.rm   = 4'($urandom);
        if (d.op == 2'd0 && d.i)
            d.imm = ($urandom_range(0, 5) == 0) ? 24'($urandom) : 24'($urandom_range(0, 255));
        else if (d.op == 2'd1)
            d.imm = ($urandom_range(0, 5) == 0) ? 24'($urandom) : 24'($urandom_range(0, 4095));
        else
            d.imm = 24'($urandom);
        d.last = 1'b0;
        return d;
    endfunction

    task automatic push_exp(input int s, input int unsigned a, input logic [31:0] w);
        exp_t e;
        e.addr = a;
        e.data = w;
        if (s == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic chk_state(input int s, input string tag);
        chk({tag, "_count"}, o_cnt(s), m_cnt[s]);
        chk({tag, "_err"},   {31'h0, o_err(s)},  {31'h0, m_err[s]});
        chk({tag, "_done"},  {31'h0, o_done(s)}, {31'h0, m_done[s]});
        chk({tag, "_busy"},  {31'h0, o_busy(s)}, {31'h0, !m_done[s]});
    endtask

    task automatic send(input int s, input desc_t d);
        logic [31:0] w;
        bit lg;
        int t;
        drv    = d;
        vld[s] = 1'b1;
        t      = 0;
        @(negedge clk);
        while (!o_rdy(s) && t < 50) begin
            t++;
            @(negedge clk);
        end
        if (!o_rdy(s)) begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready 0 want 1 (dut %0d)", s);
            vld[s] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        vld[s] = 1'b0;
        lg = ref_enc(d, w);
        if (lg) begin
            push_exp(s, m_ptr[s], w);
            m_ptr[s] = (m_ptr[s] + 1) % depth[s];
            m_cnt[s]++;
            if (m_cnt[s] == depth[s]) begin
                m_done[s] = 1'b1;
                if (!d.last) m_err[s] = 1'b1;
            end
        end else begin
            m_err[s] = 1'b1;
        end
        if (d.last) m_done[s] = 1'b1;
        chk("we_on_accept", {31'h0, o_we(s)}, {31'h0, lg});
        chk_state(s, "accept");
    endtask

    task automatic start_sess(input int s);
        st[s] = 1'b1;
        @(posedge clk);
        #1;
        st[s]     = 1'b0;
        m_ptr[s]  = base[s];
        m_cnt[s]  = 0;
        m_err[s]  = 1'b0;
        m_done[s] = 1'b0;
        chk_state(s, "start");
    endtask

    task automatic chk_reset(input int s);
        chk("rst_ready", {31'h0, o_rdy(s)},  32'h0);
        chk("rst_we",    {31'h0, o_we(s)},   32'h0);
        chk("rst_addr",  o_addr(s),          32'h0);
        chk("rst_wdata", o_wd(s),            32'h0);
        chk("rst_busy",  {31'h0, o_busy(s)}, 32'h0);
        chk("rst_done",  {31'h0, o_done(s)}, 32'h0);
        chk("rst_err",   {31'h0, o_err(s)},  32'h0);
        chk("rst_count", o_cnt(s),           32'h0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (we0) begin
            if (q0.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_write0: got addr %0h data %0h want no write", addr0, wd0);
            end else begin
                e = q0.pop_front();
                chk("wr0_addr", {26'h0, addr0}, e.addr);
                chk("wr0_data", wd0, e.data);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (we1) begin
            if (q1.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_write1: got addr %0h data %0h want no write", addr1, wd1);
            end else begin
                e = q1.pop_front();
                chk("wr1_addr", {30'h0, addr1}, e.addr);
                chk("wr1_data", wd1, e.data);
            end
        end
    end

    initial begin
        rst = 2'b11;
        st  = 2'b00;
        vld = 2'b00;
        drv = '0;
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0; m_cnt[k] = 0; m_err[k] = 1'b0; m_done[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 2'b00;
        chk_reset(0);
        chk_reset(1);

        // ADD r1,r2,r3 / SUB r4,r4,#5 with an idle cycle between.
        start_sess(0);
        send(0, mk(2'd0, 4'b0100, 4'hE, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 24'h0, 1'b0));
        @(posedge clk); #1;
        chk("add_we_one_cycle", {31'h0, we0}, 32'h0);
        send(0, mk(2'd0, 4'b0010, 4'hE, 1'b1, 1'b0, 4'd4, 4'd4, 4'd0, 24'h5, 1'b1));
        @(posedge clk); #1;
        chk("sub_we_one_cycle", {31'h0, we0}, 32'h0);

        // LDR r0,[r1,#8] then STR r0,[r1,#12] back to back.
        start_sess(0);
        send(0, mk(2'd1, 4'h0, 4'hE, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0, 24'd8,  1'b0));
        send(0, mk(2'd1, 4'h0, 4'hE, 1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 24'd12, 1'b1));

        // Branch, cond 0, negative offset; in_ready must be low after the final accept.
        start_sess(0);
        send(0, mk(2'd2, 4'h0, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'hFFFFFE, 1'b1));
        chk("branch_ready_low", {31'h0, rdy0}, 32'h0);

        // Illegal descriptors around one legal ADD.
        start_sess(0);
        send(0, mk(2'd0, 4'b0100, 4'hE, 1'b1, 1'b0, 4'd1, 4'd2, 4'd0, 24'h100, 1'b0));
        send(0, mk(2'd0, 4'b0100, 4'hE, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 24'h0,   1'b0));
        send(0, mk(2'd3, 4'b0100, 4'hE, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 24'h0,   1'b0));
        send(0, mk(2'd0, 4'b1111, 4'hE, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 24'h0,   1'b1));

        // Reset right after an accept, with in_valid still high.
        start_sess(0);
        send(0, mk(2'd0, 4'b0100, 4'hE, 1'b0, 1'b0, 4'd5, 4'd6, 4'd7, 24'h0, 1'b0));
        vld[0] = 1'b1;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        vld[0] = 1'b0;
        m_ptr[0] = 0; m_cnt[0] = 0; m_err[0] = 1'b0; m_done[0] = 1'b1;
        chk_reset(0);
        start_sess(0);
        send(0, mk(2'd0, 4'b1100, 4'hE, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 24'h0, 1'b1));

        // Randomized session with random gaps; may overflow the 64-word memory.
        start_sess(0);
        for (int n = 0; n < 72 && !m_done[0]; n++) begin
            desc_t d;
            d = rnd();
            d.last = (n == 71) || ($urandom_range(0, 39) == 0);
            send(0, d);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        // Small memory, nonzero base: wraps 2,3,0,1 then closes on overflow.
        start_sess(1);
        for (int n = 0; n < 4; n++)
            send(1, mk(2'd0, 4'b0100, 4'hE, 1'b0, 1'b0, 4'(n), 4'd2, 4'd3, 24'h0, 1'b0));
        drv    = mk(2'd2, 4'h0, 4'hE, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'h10, 1'b0);
        vld[1] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("overflow_no_accept", {31'h0, rdy1}, 32'h0);
        end
        vld[1] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("q0_drained", q0.size(), 32'h0);
        chk("q1_drained", q1.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
